// File: rtl/bellek_yanitlayici.sv
// bellek_yanitlayici -- memory-side responder for the multicycle core.
//
// Accepts one word access per request, waits BEKLEME cycles, then returns
// read data (old contents, read-before-write) or commits write data, with a
// one-cycle `hazir` pulse. Backed by a word-organised internal RAM.
//
// Optional feature macro: BELLEK_SINIR_DENETIM_EN
//   defined   : misaligned or out-of-range accesses report `hata`, return 0
//               and suppress the write.
//   undefined : `hata` tied to 0, address wraps modulo SATIR_SAYISI.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   istek     in   access request, held until `hazir` is sampled
//   adres     in   byte address
//   yaz       in   1 = write, 0 = read
//   yaz_veri  in   write data
//   oku_veri  out  read data, non-zero only while `hazir`
//   hazir     out  access complete, one-cycle pulse
//   hata      out  access error, only while `hazir`
//   mesgul    out  request captured and not yet completed
module bellek_yanitlayici #(
  parameter int unsigned          ADRES_BIT    = 32,
  parameter int unsigned          VERI_BIT     = 32,
  parameter int unsigned          SATIR_SAYISI = 4096,
  parameter int unsigned          BEKLEME      = 2,
  parameter logic [ADRES_BIT-1:0] BELLEK_ADRES = ADRES_BIT'(32'h8000_0000)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 istek,
  input  logic [ADRES_BIT-1:0] adres,
  input  logic                 yaz,
  input  logic [VERI_BIT-1:0]  yaz_veri,
  output logic [VERI_BIT-1:0]  oku_veri,
  output logic                 hazir,
  output logic                 hata,
  output logic                 mesgul
);

  localparam int unsigned SATIR_BIT = $clog2(SATIR_SAYISI);
  localparam logic [3:0]  BEKLEME_Y = 4'(BEKLEME);

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    BEKLE = 2'd1,
    YANIT = 2'd2
  } durum_t;

  durum_t               durum_q, durum_d;
  logic [3:0]           sayac_q, sayac_d;
  logic [ADRES_BIT-1:0] adres_q, adres_d;
  logic                 yaz_q, yaz_d;
  logic [VERI_BIT-1:0]  veri_q, veri_d;
  logic [VERI_BIT-1:0]  oku_veri_q, oku_veri_d;
  logic                 hata_q, hata_d;
  logic                 yanit_giris;
  logic                 yaz_en;

  logic [VERI_BIT-1:0]  ram_q [SATIR_SAYISI];

  // With BEKLEME=0 the capture edge is also the YANIT entry edge, so the
  // access must be served straight from the inputs rather than the registers.
  logic [ADRES_BIT-1:0] adres_e;
  logic                 yaz_e;
  logic [VERI_BIT-1:0]  veri_e;
  logic [ADRES_BIT-1:0] fark;
  logic [SATIR_BIT-1:0] satir;
  logic                 hata_e;

  assign adres_e = (durum_q == BOSTA) ? adres    : adres_q;
  assign yaz_e   = (durum_q == BOSTA) ? yaz      : yaz_q;
  assign veri_e  = (durum_q == BOSTA) ? yaz_veri : veri_q;
  assign fark    = adres_e - BELLEK_ADRES;
  assign satir   = fark[SATIR_BIT+1:2];

`ifdef BELLEK_SINIR_DENETIM_EN
  // Addresses below the base wrap to huge indices and fail the range test.
  assign hata_e = (adres_e[1:0] != 2'b00) ||
                  ((fark >> 2) >= ADRES_BIT'(SATIR_SAYISI));
`else
  assign hata_e = 1'b0;
  logic unused_adres;
  assign unused_adres = ^{fark[ADRES_BIT-1:SATIR_BIT+2], fark[1:0]};
`endif

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    durum_d     = durum_q;
    sayac_d     = sayac_q;
    adres_d     = adres_q;
    yaz_d       = yaz_q;
    veri_d      = veri_q;
    oku_veri_d  = '0;
    hata_d      = 1'b0;
    yanit_giris = 1'b0;

    unique case (durum_q)
      BOSTA: begin
        if (istek) begin
          adres_d = adres;
          yaz_d   = yaz;
          veri_d  = yaz_veri;
          sayac_d = BEKLEME_Y;
          if (BEKLEME_Y == 4'd0) begin
            durum_d     = YANIT;
            yanit_giris = 1'b1;
          end else begin
            durum_d = BEKLE;
          end
        end
      end
      BEKLE: begin
        sayac_d = sayac_q - 4'd1;
        if (sayac_q <= 4'd1) begin
          durum_d     = YANIT;
          yanit_giris = 1'b1;
        end
      end
      YANIT:   durum_d = BOSTA;
      default: durum_d = BOSTA;
    endcase

    // Read data and error are registered on the YANIT entry edge; leaving
    // YANIT loads the zero defaults, keeping both outputs 0 elsewhere.
    if (yanit_giris) begin
      oku_veri_d = hata_e ? '0 : ram_q[satir];
      hata_d     = hata_e;
    end
  end

  // Gating with rst_n drops a write whose entry edge arrives during reset.
  assign yaz_en = yanit_giris && yaz_e && !hata_e && rst_n;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q    <= BOSTA;
      sayac_q    <= '0;
      adres_q    <= '0;
      yaz_q      <= 1'b0;
      veri_q     <= '0;
      oku_veri_q <= '0;
      hata_q     <= 1'b0;
    end else begin
      durum_q    <= durum_d;
      sayac_q    <= sayac_d;
      adres_q    <= adres_d;
      yaz_q      <= yaz_d;
      veri_q     <= veri_d;
      oku_veri_q <= oku_veri_d;
      hata_q     <= hata_d;
    end
  end

  // NOTE: the RAM array is deliberately not reset; clearing thousands of
  // words would force it out of a RAM macro into flops.
  always_ff @(posedge clk) begin
    if (yaz_en) ram_q[satir] <= veri_e;
  end

  assign oku_veri = oku_veri_q;
  assign hata     = hata_q;
  assign hazir    = (durum_q == YANIT);
  assign mesgul   = (durum_q != BOSTA);

endmodule

// File: tb/tb_bellek_yanitlayici.sv
// Self-checking bench for bellek_yanitlayici: a cycle-indexed behavioural
// model (edge numbers, an associative word store) predicts every output on
// every cycle of the BEKLEME=2 instance; a second BEKLEME=0 instance checks
// back-to-back pulsing. Directed tests pin literal values.
module tb_bellek_yanitlayici;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned SATIR = 4096;
  localparam int          GECIK = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        istek = 1'b0, yaz = 1'b0;
  logic [31:0] adres = '0, yaz_veri = '0;
  logic [31:0] oku_veri;
  logic        hazir, hata, mesgul;

  logic        istek0 = 1'b0, yaz0 = 1'b0;
  logic [31:0] adres0 = '0, yaz_veri0 = '0;
  logic [31:0] oku_veri0;
  logic        hazir0, hata0, mesgul0;

  int hata_sayisi = 0;
  int kontrol_sayisi = 0;

  always #5 clk = ~clk;

  bellek_yanitlayici #(.BEKLEME(GECIK)) u_dut (
    .clk(clk), .rst_n(rst_n), .istek(istek), .adres(adres), .yaz(yaz),
    .yaz_veri(yaz_veri), .oku_veri(oku_veri), .hazir(hazir), .hata(hata),
    .mesgul(mesgul)
  );

  bellek_yanitlayici #(.BEKLEME(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .istek(istek0), .adres(adres0), .yaz(yaz0),
    .yaz_veri(yaz_veri0), .oku_veri(oku_veri0), .hazir(hazir0), .hata(hata0),
    .mesgul(mesgul0)
  );

  task automatic check(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
    kontrol_sayisi++;
    if (gercek !== beklenen) begin
      hata_sayisi++;
      $display("FAIL %s: got %h expected %h at %0t", ad, gercek, beklenen, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mem [int unsigned];
  int          kenar = 0;
  int          kabul = -10;
  int          yanit = -10;
  bit          gecerli = 0;
  logic [31:0] bek_oku;
  bit          bek_oku_bilinen, bek_hata, bek_yaz;
  int unsigned bek_idx;
  logic [31:0] bek_veri;

  function automatic bit hesapla(input logic [31:0] a, output int unsigned idx);
    logic [31:0] fark;
    int unsigned kelime;
    fark   = a - BASE;
    kelime = fark >> 2;
`ifdef BELLEK_SINIR_DENETIM_EN
    idx = kelime;
    return (a[1:0] != 2'b00) || (kelime >= SATIR);
`else
    idx = kelime % SATIR;
    return 1'b0;
`endif
  endfunction

  always @(negedge rst_n) begin
    gecerli = 0;
    kabul   = -10;
    yanit   = -10;
  end

  always @(posedge clk) begin
    bit          err;
    int unsigned idx;
    kenar = kenar + 1;
    if (rst_n) begin
      // A new access is accepted once the previous YANIT cycle and the
      // following idle cycle have both passed.
      if (istek && kenar >= yanit + 2) begin
        err             = hesapla(adres, idx);
        gecerli         = 1;
        kabul           = kenar;
        yanit           = kenar + GECIK;
        bek_hata        = err;
        bek_oku_bilinen = err || mem.exists(idx);
        bek_oku         = (err || !mem.exists(idx)) ? 32'h0 : mem[idx];
        bek_yaz         = yaz && !err;
        bek_idx         = idx;
        bek_veri        = yaz_veri;
      end
      if (gecerli && kenar == yanit && bek_yaz) mem[bek_idx] = bek_veri;
    end
  end

  always @(negedge clk) begin
    bit hz, mg;
    if (!rst_n) begin
      check("reset_hazir", 32'(hazir), 32'd0);
      check("reset_mesgul", 32'(mesgul), 32'd0);
      check("reset_oku", oku_veri, 32'd0);
      check("reset_hata", 32'(hata), 32'd0);
    end else begin
      hz = gecerli && (kenar == yanit);
      mg = gecerli && (kenar >= kabul) && (kenar <= yanit);
      check("hazir", 32'(hazir), 32'(hz));
      check("mesgul", 32'(mesgul), 32'(mg));
      if (hz) begin
        check("hata", 32'(hata), 32'(bek_hata));
        if (bek_oku_bilinen) check("oku_veri", oku_veri, bek_oku);
      end else begin
        check("bos_oku", oku_veri, 32'd0);
        check("bos_hata", 32'(hata), 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic erisim(input logic [31:0] a, input logic y, input logic [31:0] v,
                        input bit birak, output logic [31:0] oku_o, output logic hata_o,
                        output int gecikme, output int mesgul_say);
    @(posedge clk); #1;
    istek = 1'b1; adres = a; yaz = y; yaz_veri = v;
    @(posedge clk);
    if (birak) begin #1; istek = 1'b0; end
    gecikme = 0; mesgul_say = 0; oku_o = '0; hata_o = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (mesgul) mesgul_say++;
      if (hazir) begin
        gecikme = n; oku_o = oku_veri; hata_o = hata;
        break;
      end
    end
    istek = 1'b0;
    if (gecikme == 0) check("zaman_asimi", 32'd0, 32'd1);
    @(negedge clk);
    if (mesgul) mesgul_say++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] o;
    logic        h;
    int          gk, ms, son, darbe;
    logic [31:0] onceki;

    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;

    // Preload and first read: latency and busy window.
    erisim(BASE, 1'b1, 32'h4020_8063, 0, o, h, gk, ms);
    erisim(BASE, 1'b0, 32'h0, 0, o, h, gk, ms);
    check("onyukle_oku", o, 32'h4020_8063);
    check("onyukle_hata", 32'(h), 32'd0);
    check("gecikme", 32'(gk), 32'd3);
    check("mesgul_suresi", 32'(ms), 32'd3);

    // Write then read; the write's own response shows the old word.
    erisim(BASE + 32'h10, 1'b1, 32'h0, 0, o, h, gk, ms);
    erisim(BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 0, o, h, gk, ms);
    check("yazmadan_once_oku", o, 32'h0);
    erisim(BASE + 32'h10, 1'b0, 32'h0, 0, o, h, gk, ms);
    check("geri_oku", o, 32'hDEAD_BEEF);

    // Reset during BEKLE discards the pending write.
    erisim(BASE + 32'h20, 1'b1, 32'h0, 0, o, h, gk, ms);
    @(posedge clk); #1;
    istek = 1'b1; adres = BASE + 32'h20; yaz = 1'b1; yaz_veri = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0; istek = 1'b0;
    #1;
    check("rst_hazir", 32'(hazir), 32'd0);
    check("rst_mesgul", 32'(mesgul), 32'd0);
    check("rst_oku", oku_veri, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    erisim(BASE + 32'h20, 1'b0, 32'h0, 0, o, h, gk, ms);
    check("iptal_yazma", o, 32'h0);

`ifdef BELLEK_SINIR_DENETIM_EN
    erisim(BASE + 32'h22, 1'b0, 32'h0, 0, o, h, gk, ms);
    check("hizasiz_hata", 32'(h), 32'd1);
    check("hizasiz_oku", o, 32'h0);
    erisim(BASE + 32'h4000, 1'b1, 32'hFFFF_FFFF, 0, o, h, gk, ms);
    check("sinir_hata", 32'(h), 32'd1);
    erisim(BASE, 1'b0, 32'h0, 0, o, h, gk, ms);
    check("sinir_kelime0", o, 32'h4020_8063);
`else
    erisim(BASE + 32'h4000, 1'b1, 32'hA5A5_A5A5, 0, o, h, gk, ms);
    check("sarma_hata", 32'(h), 32'd0);
    erisim(BASE, 1'b0, 32'h0, 0, o, h, gk, ms);
    check("sarma_kelime0", o, 32'hA5A5_A5A5);
`endif

    // Random traffic; the model checks every cycle.
    for (int i = 0; i < 200; i++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r < 7)       a = BASE + 4 * $urandom_range(0, 15);
      else if (r == 7) a = BASE + $urandom_range(0, 63);
      else if (r == 8) a = BASE + 4 * (SATIR + $urandom_range(0, 15));
      else             a = BASE - 4 * $urandom_range(1, 8);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      erisim(a, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 4) == 0),
             o, h, gk, ms);
    end

    // BEKLEME=0 with istek held: a pulse every second cycle, one access each.
    @(posedge clk); #1;
    istek0 = 1'b1; yaz0 = 1'b1; adres0 = BASE + 32'h4; yaz_veri0 = 32'd100;
    son = -1; darbe = 0; onceki = '0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      check("b0_mesgul", 32'(mesgul0), 32'(hazir0));
      if (hazir0) begin
        if (son >= 0) begin
          check("b0_aralik", 32'(n - son), 32'd2);
          check("b0_oku", oku_veri0, onceki);
        end
        onceki = yaz_veri0;
        son = n;
        darbe++;
        yaz_veri0 = yaz_veri0 + 32'd1;
      end
    end
    istek0 = 1'b0;
    check("b0_darbe", 32'(darbe), 32'd8);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", hata_sayisi, kontrol_sayisi);
    $finish;
  end

endmodule

// File: doc/bellek_yanitlayici.md
# bellek_yanitlayici

Memory-side responder for the multicycle core's data/instruction bus: accepts one word access per request, inserts a fixed number of wait states, then returns read data or commits write data, signalling completion with a one-cycle `hazir` pulse. It sits between the core's memory port and a word-organised internal RAM. It replaces the zero-latency main memory model, so the core's stall path (`ilerle_cmb` deasserted while waiting) is exercised with real wait states.

## Interface
- `BELLEK_ADRES`, 32'h8000_0000, byte address of word 0
- `ADRES_BIT`, 32, address width
- `VERI_BIT`, 32, data width, one word per access
- `SATIR_SAYISI`, 4096, number of words in the RAM
- `BEKLEME`, 2, wait states per access, legal range 0..15

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `istek`  in  1  access request; held high by the core until it samples `hazir`
- `adres`  in  ADRES_BIT  byte address
- `yaz`  in  1  1 = write, 0 = read
- `yaz_veri`  in  VERI_BIT  write data
- `oku_veri`  out  VERI_BIT  read data, valid only while `hazir`=1
- `hazir`  out  1  access complete, one-cycle pulse
- `hata`  out  1  access error, valid only while `hazir`=1
- `mesgul`  out  1  request captured and not yet completed

## Operation
- FSM states: BOSTA, BEKLE, YANIT. Reset state is BOSTA.
- BOSTA, `istek`=1: capture `adres`, `yaz`, `yaz_veri` into registers. Load the wait counter with BEKLEME. Go to BEKLE, or to YANIT directly when BEKLEME=0.
- BEKLE: decrement the counter each cycle. When the counter reaches 0, go to YANIT. Inputs are ignored while in BEKLE.
- Transition into YANIT, on the same edge:
  - register `oku_veri` with the RAM word at the captured index (old contents, read-before-write);
  - if `yaz`=1 and no error, write the captured data;
  - register `hata`.
- YANIT: `hazir`=1 for exactly one cycle, then BOSTA unconditionally. `istek` is ignored in YANIT, because the core still holds it.
- Word index = (captured `adres` − BELLEK_ADRES) >> 2, unsigned, ADRES_BIT-wide subtraction.
- Outside YANIT: `oku_veri`=0 and `hata`=0.
- Writes are always full-word. There is no byte enable.

## Timing
- Reset values (asynchronous): state BOSTA, `hazir`=0, `hata`=0, `oku_veri`=0, `mesgul`=0, counter 0. RAM contents are not reset.
- Latency: `hazir` goes high BEKLEME+1 cycles after the accepting edge.
- Back-to-back accesses: the minimum spacing between accepting edges is BEKLEME+2.
- `mesgul`=1 from the edge after acceptance through the YANIT cycle, inclusive.
- If `istek` drops during BEKLE (protocol violation), the access still completes and `hazir` still pulses. Aborts are not supported.
- Reset asserted mid-access: the FSM returns to BOSTA immediately.
  - A write not yet committed, i.e. before the YANIT entry edge, is discarded.
  - No `hazir` is produced.

## Configuration
- `BELLEK_SINIR_DENETIM_EN` defined:
  - `hata`=1 in YANIT when `adres[1:0]`≠0, or when the index is ≥ SATIR_SAYISI (this includes any `adres` below BELLEK_ADRES, via unsigned wrap);
  - on error, `oku_veri`=0 and the write is suppressed.
- Undefined:
  - `hata` is tied to 0;
  - `adres[1:0]` is ignored;
  - the index is taken modulo SATIR_SAYISI (low log2 bits), so all accesses wrap into the RAM.

## Test plan
- Write test (BEKLEME=2):
  - reset, then preload word 0 = 32'h4020_8063;
  - read `adres`=32'h8000_0000 → `hazir` 3 cycles after acceptance with `oku_veri`=32'h4020_8063, `hata`=0;
  - `mesgul` is high for exactly 3 cycles.
- Write then read: write 32'hDEAD_BEEF to 32'h8000_0010, then read it back → second access returns 32'hDEAD_BEEF. Read-before-write check: the write's own `hazir` cycle shows the old word, 0.
- BEKLEME=0, `istek` held high continuously → `hazir` pulses every 2nd cycle, and each access is accepted exactly once.
- Reset mid-access: assert `rst_n`=0 during BEKLE of a write of 32'h1234_5678 to 32'h8000_0020 → outputs go to 0 immediately, no `hazir` is produced, and a later read of 32'h8000_0020 returns 0.
- With `BELLEK_SINIR_DENETIM_EN`:
  - read of 32'h8000_0022 → `hata`=1, `oku_veri`=0;
  - write to 32'h8000_0000 + 4·SATIR_SAYISI → `hata`=1 and no RAM word changes.
- Without the macro: write 32'hA5A5_A5A5 to 32'h8000_0000 + 4·SATIR_SAYISI → `hata`=0, and word 0 reads back 32'hA5A5_A5A5.
